fetch_branch_unit: RTL and testbench

Parametrised instruction-fetch and branch-resolution unit for the Simple RISC Machine core. It owns the program counter, instruction register and memory-address arbitration. It adds a memory-ready handshake, conditional and unconditional branches, link and return branches, and HALT. It sits between the shared memory port and the execute controller/datapath, replacing the fixed 9-bit PC/IR/address-mux arrangement.

---
 rtl/fetch_branch_unit.sv | 160 ++++++++++++++++
 tb/tb_fetch_branch_unit.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_branch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_branch_unit
//  Purpose  : Instruction fetch and branch resolution for the Simple RISC
//             Machine core. Owns PC and IR, arbitrates the shared memory
//             port between instruction fetch and execute-phase data
//             accesses, and resolves B/Bcc/BL/BX/BLX and HALT.
//  Ports    : clk, reset (sync, active-low)
//             read_data, mem_ready          - memory response
//             mem_cmd, mem_addr             - memory command / address
//             ir, ir_valid                  - current instruction
//             exec_done                     - execute controller finished
//             data_req, data_we, data_addr  - execute-phase data access
//             data_ack                      - data access completed
//             N, V, Z, reg_data             - flags and Rd for BX/BLX
//             link_write, link_value        - R7 link write
//             pc, halted                    - status
//  Revision : 1.0  initial release
// ============================================================================
module fetch_branch_unit #(
   parameter int             AW       = 9,
   parameter int             DW       = 16,
   parameter logic [AW-1:0]  RESET_PC = '0
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [DW-1:0] read_data,
   input  logic          mem_ready,
   output logic [1:0]    mem_cmd,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] ir,
   output logic          ir_valid,
   input  logic          exec_done,
   input  logic          data_req,
   input  logic          data_we,
   input  logic [AW-1:0] data_addr,
   output logic          data_ack,
   input  logic          N,
   input  logic          V,
   input  logic          Z,
   input  logic [AW-1:0] reg_data,
   output logic          link_write,
   output logic [AW-1:0] link_value,
   output logic [AW-1:0] pc,
   output logic          halted
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_FETCH = 2'd1;
   localparam logic [1:0] S_EXEC  = 2'd2;
   localparam logic [1:0] S_HALT  = 2'd3;

   localparam logic [1:0] CMD_NONE  = 2'b00;
   localparam logic [1:0] CMD_READ  = 2'b01;
   localparam logic [1:0] CMD_WRITE = 2'b10;

   localparam logic [AW-1:0] PC_INC = AW'(1);

   logic [1:0]    state;
   logic [AW-1:0] sximm8;
   logic [AW-1:0] branch_pc;
   logic          is_link;
   logic          cond_true;
   logic [2:0]    opcode;

   assign opcode     = ir[15:13];
   assign link_value = pc;   // pc already points past the branch

   // Offset is sign-extended for wide PCs, simply truncated for narrow ones.
   generate
      if (AW > 8) begin : g_sext
         assign sximm8 = {{(AW-8){ir[7]}}, ir[7:0]};
      end else begin : g_trunc
         assign sximm8 = ir[AW-1:0];
      end
   endgenerate

   always_comb begin
      cond_true = 1'b0;
      case (ir[10:8])
         3'b000:  cond_true = 1'b1;
         3'b001:  cond_true = Z;
         3'b010:  cond_true = ~Z;
         3'b011:  cond_true = N ^ V;
         3'b100:  cond_true = (N ^ V) | Z;
         default: cond_true = 1'b0;
      endcase
   end

   // Target PC if this instruction completes now; non-branches keep pc.
   always_comb begin
      branch_pc = pc;
      is_link   = 1'b0;
      if (opcode == 3'b001) begin
         if (cond_true) branch_pc = pc + sximm8;
      end else if (opcode == 3'b010) begin
         case (ir[12:11])
            2'b11: begin branch_pc = pc + sximm8; is_link = 1'b1; end
            2'b00: branch_pc = reg_data;
            2'b10: begin branch_pc = reg_data;    is_link = 1'b1; end
            default: branch_pc = pc;
         endcase
      end
   end

   always_comb begin
      mem_cmd    = CMD_NONE;
      mem_addr   = pc;
      data_ack   = 1'b0;
      ir_valid   = 1'b0;
      link_write = 1'b0;
      halted     = 1'b0;
      case (state)
         S_FETCH: mem_cmd = CMD_READ;
         S_EXEC: begin
            ir_valid   = 1'b1;
            link_write = exec_done & is_link;
            if (data_req) begin
               mem_addr = data_addr;
               mem_cmd  = data_we ? CMD_WRITE : CMD_READ;
               data_ack = mem_ready;
            end
         end
         S_HALT:  halted = 1'b1;
         default: mem_cmd = CMD_NONE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= S_IDLE;
         pc    <= RESET_PC;
         ir    <= '0;
      end else begin
         case (state)
            S_IDLE: state <= S_FETCH;
            S_FETCH: begin
               if (mem_ready) begin
                  ir    <= read_data;
                  pc    <= pc + PC_INC;
                  state <= S_EXEC;
               end
            end
            S_EXEC: begin
               // HALT does not wait for the execute controller.
               if (opcode == 3'b111) begin
                  state <= S_HALT;
               end else if (exec_done) begin
                  // A still-pending data access is dropped here.
                  pc    <= branch_pc;
                  state <= S_FETCH;
               end
            end
            default: state <= S_HALT;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fetch_branch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_branch_unit
//  Purpose  : Self-checking bench for fetch_branch_unit (AW=9, DW=16).
//             Stimulus pushes expected fetch / data / link events into a
//             queue; a negedge monitor pops and compares them as the DUT
//             produces them. State values are checked directly.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fetch_branch_unit;

   localparam int AW = 9;
   localparam int DW = 16;

   localparam logic [1:0] EV_FETCH = 2'd0;
   localparam logic [1:0] EV_DATA  = 2'd1;
   localparam logic [1:0] EV_LINK  = 2'd2;

   typedef struct packed {
      logic [1:0]    kind;
      logic [1:0]    cmd;
      logic [AW-1:0] addr;
   } ev_t;

   logic          clk = 1'b0;
   logic          reset;
   logic [DW-1:0] read_data;
   logic          mem_ready;
   logic [1:0]    mem_cmd;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] ir;
   logic          ir_valid;
   logic          exec_done;
   logic          data_req;
   logic          data_we;
   logic [AW-1:0] data_addr;
   logic          data_ack;
   logic          N, V, Z;
   logic [AW-1:0] reg_data;
   logic          link_write;
   logic [AW-1:0] link_value;
   logic [AW-1:0] pc;
   logic          halted;

   int  compared   = 0;
   int  mismatched = 0;
   bit  mon_en     = 1'b0;
   ev_t exp_q[$];

   fetch_branch_unit #(.AW(AW), .DW(DW), .RESET_PC('0)) dut (
      .clk(clk), .reset(reset), .read_data(read_data), .mem_ready(mem_ready),
      .mem_cmd(mem_cmd), .mem_addr(mem_addr), .ir(ir), .ir_valid(ir_valid),
      .exec_done(exec_done), .data_req(data_req), .data_we(data_we),
      .data_addr(data_addr), .data_ack(data_ack), .N(N), .V(V), .Z(Z),
      .reg_data(reg_data), .link_write(link_write), .link_value(link_value),
      .pc(pc), .halted(halted)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push(input logic [1:0] kind, input logic [1:0] cmd, input logic [AW-1:0] addr);
      ev_t e;
      e.kind = kind; e.cmd = cmd; e.addr = addr;
      exp_q.push_back(e);
   endtask

   task automatic observe(input logic [1:0] kind, input logic [1:0] cmd, input logic [AW-1:0] addr);
      ev_t e;
      compared++;
      if (exp_q.size() == 0) begin
         mismatched++;
         $display("FAIL sb_unexpected: got kind=%0d cmd=%0d addr=%0d, expected no event",
                  kind, cmd, addr);
      end else begin
         e = exp_q.pop_front();
         if (e.kind !== kind || e.cmd !== cmd || e.addr !== addr) begin
            mismatched++;
            $display("FAIL sb_event: got kind=%0d cmd=%0d addr=%0d expected kind=%0d cmd=%0d addr=%0d",
                     kind, cmd, addr, e.kind, e.cmd, e.addr);
         end
      end
   endtask

   // Monitor: fetch handshakes, data acknowledges and link pulses.
   always @(negedge clk) begin
      if (mon_en && reset) begin
         if (!ir_valid && mem_cmd == 2'b01 && mem_ready) observe(EV_FETCH, mem_cmd, mem_addr);
         if (data_ack)   observe(EV_DATA, mem_cmd, mem_addr);
         if (link_write) observe(EV_LINK, 2'b00, link_value);
      end
   end

   // Wait for FETCH, stall `waits` cycles, then return `word`.
   task automatic fetch(input logic [15:0] word, input int waits, input logic [AW-1:0] addr);
      logic [AW-1:0] nxt;
      nxt = addr + 9'd1;
      push(EV_FETCH, 2'b01, addr);
      mem_ready = 1'b0;
      for (int i = 0; i < 10 && !(mem_cmd == 2'b01 && !ir_valid); i++) step();
      if (!(mem_cmd == 2'b01 && !ir_valid)) begin
         compared++;
         mismatched++;
         $display("FAIL fetch_timeout: got mem_cmd=%0d expected 1 within 10 cycles", mem_cmd);
      end
      for (int i = 0; i < waits; i++) begin
         chk("wait_cmd", 32'(mem_cmd), 32'd1);
         chk("wait_pc", 32'(pc), 32'(addr));
         step();
      end
      mem_ready = 1'b1;
      read_data = word;
      step();
      mem_ready = 1'b0;
      chk("fetch_ir", 32'(ir), 32'(word));
      chk("fetch_pc", 32'(pc), 32'(nxt));
      chk("fetch_ir_valid", 32'(ir_valid), 32'd1);
   endtask

   task automatic exec(input logic n, input logic v, input logic z,
                       input logic [AW-1:0] rd, input bit lnk, input logic [AW-1:0] lval);
      N = n; V = v; Z = z; reg_data = rd;
      if (lnk) push(EV_LINK, 2'b00, lval);
      exec_done = 1'b1;
      step();
      exec_done = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, expected finish before 200000");
      $fatal(1, "watchdog");
   end

   initial begin
      int bad;
      reset = 1'b0; read_data = '0; mem_ready = 1'b0; exec_done = 1'b0;
      data_req = 1'b0; data_we = 1'b0; data_addr = '0;
      N = 1'b0; V = 1'b0; Z = 1'b0; reg_data = '0;
      step(); step();
      mon_en = 1'b1;
      chk("rst_pc", 32'(pc), 32'd0);
      chk("rst_ir", 32'(ir), 32'd0);
      chk("rst_cmd", 32'(mem_cmd), 32'd0);
      chk("rst_ir_valid", 32'(ir_valid), 32'd0);
      chk("rst_halted", 32'(halted), 32'd0);

      reset = 1'b1; mem_ready = 1'b1; read_data = 16'hD105;
      step();
      chk("first_fetch_cmd", 32'(mem_cmd), 32'd1);
      chk("first_fetch_addr", 32'(mem_addr), 32'd0);
      fetch(16'hD105, 0, 9'd0);   exec(0, 0, 0, 9'd0, 0, 9'd0);
      fetch(16'h2003, 3, 9'd1);   exec(0, 0, 0, 9'd0, 0, 9'd0);   // B +3 -> 5
      fetch(16'h2103, 0, 9'd5);   exec(0, 0, 1, 9'd0, 0, 9'd0);   // BEQ taken -> 9
      fetch(16'h2103, 0, 9'd9);   exec(0, 0, 0, 9'd0, 0, 9'd0);   // BEQ not taken -> 10
      fetch(16'h5804, 0, 9'd10);  exec(0, 0, 0, 9'd0, 1, 9'd11);  // BL +4 -> 15
      fetch(16'h23FE, 0, 9'd15);  exec(1, 0, 0, 9'd0, 0, 9'd0);   // BLT -2 -> 14
      fetch(16'h4000, 0, 9'd14);  exec(0, 0, 0, 9'd11, 0, 9'd0);  // BX -> 11
      fetch(16'h5000, 0, 9'd11);  exec(0, 0, 0, 9'd3, 1, 9'd12);  // BLX -> 3
      fetch(16'h2205, 0, 9'd3);   exec(0, 0, 1, 9'd0, 0, 9'd0);   // BNE not taken
      fetch(16'h2505, 0, 9'd4);   exec(1, 0, 1, 9'd0, 0, 9'd0);   // code 101 never taken
      fetch(16'h2402, 0, 9'd5);   exec(0, 0, 0, 9'd0, 0, 9'd0);   // BLE not taken
      fetch(16'h4804, 0, 9'd6);   exec(0, 0, 0, 9'd99, 0, 9'd0);  // 010/01 no change

      fetch(16'hD105, 0, 9'd7);
      data_req = 1'b1; data_we = 1'b1; data_addr = 9'h040; mem_ready = 1'b0;
      #1;
      chk("dwr_cmd", 32'(mem_cmd), 32'd2);
      chk("dwr_addr", 32'(mem_addr), 32'h40);
      chk("dwr_ack_wait", 32'(data_ack), 32'd0);
      step();
      mem_ready = 1'b1;
      push(EV_DATA, 2'b10, 9'h040);
      #1;
      chk("dwr_ack", 32'(data_ack), 32'd1);
      step();
      data_we = 1'b0; data_addr = 9'h01F;
      push(EV_DATA, 2'b01, 9'h01F);
      step();
      data_req = 1'b0; mem_ready = 1'b0;
      #1;
      chk("data_idle_cmd", 32'(mem_cmd), 32'd0);
      exec(0, 0, 0, 9'd0, 0, 9'd0);

      fetch(16'h20F6, 0, 9'd8);   exec(0, 0, 0, 9'd0, 0, 9'd0);   // B -10 -> 511
      fetch(16'hD105, 0, 9'd511); exec(0, 0, 0, 9'd0, 0, 9'd0);   // pc wraps to 0
      fetch(16'hD105, 0, 9'd0);   exec(0, 0, 0, 9'd0, 0, 9'd0);
      fetch(16'hD105, 0, 9'd1);   exec(0, 0, 0, 9'd0, 0, 9'd0);
      fetch(16'h21FC, 0, 9'd2);   exec(0, 0, 1, 9'd0, 0, 9'd0);   // BEQ -4 -> 511
      fetch(16'hE000, 0, 9'd511);
      step();
      chk("halt_flag", 32'(halted), 32'd1);
      chk("halt_ir_valid", 32'(ir_valid), 32'd0);
      chk("halt_pc", 32'(pc), 32'd0);
      chk("halt_ir", 32'(ir), 32'hE000);
      mem_ready = 1'b1; exec_done = 1'b1;
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         if (mem_cmd != 2'b00 || !halted || link_write || pc != 9'd0) bad++;
         step();
      end
      chk("halt_held_bad_cycles", 32'(bad), 32'd0);
      exec_done = 1'b0; mem_ready = 1'b0;

      reset = 1'b0; step();
      reset = 1'b1; step(); step();
      chk("midwait_cmd", 32'(mem_cmd), 32'd1);
      reset = 1'b0; step();
      chk("midwait_rst_pc", 32'(pc), 32'd0);
      chk("midwait_rst_ir", 32'(ir), 32'd0);
      chk("midwait_rst_cmd", 32'(mem_cmd), 32'd0);
      chk("midwait_rst_halted", 32'(halted), 32'd0);
      reset = 1'b1;
      fetch(16'hD105, 0, 9'd0);

      step(); step();
      chk("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
`default_nettype wire
